prog_loader: RTL and testbench

Serial-to-memory program loader: accepts a framed byte stream from a host over a valid/ready handshake and writes the payload into the core's data RAM over the same addr/data/ram_ena/ram_write bus the core reads from. The core is held off (`core_hold`) for the whole load and released only after a checksum-verified frame. The loader sits beside the core at top level and is the writer on the memory interface the core consumes.

---
 rtl/prog_loader_pkg.sv | 25 ++
 rtl/prog_loader.sv | 141 ++++++++++++++
 tb/tb_prog_loader.sv | 309 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/prog_loader_pkg.sv
// Shared definitions for the program loader: core memory map and loader FSM encoding.
package prog_loader_pkg;

  localparam int unsigned DATA_W    = 8;
  localparam int unsigned ADDR_W    = 8;
  localparam int unsigned RAM_DEPTH = 256;

  localparam logic [ADDR_W-1:0] DEFAULT_BASE_ADDR = 8'h00;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LEN   = 3'd1,
    S_DATA  = 3'd2,
    S_WRITE = 3'd3,
    S_CSUM  = 3'd4,
    S_DONE  = 3'd5,
    S_ERR   = 3'd6
  } state_t;

  // A LEN byte of zero stands for a full 256-byte payload.
  function automatic logic [8:0] payload_len(input logic [DATA_W-1:0] len);
    return (len == '0) ? 9'(RAM_DEPTH) : {1'b0, len};
  endfunction

endpackage

// File: rtl/prog_loader.sv
// Framed host-to-RAM program loader; holds the core off until a checksum-verified frame lands.
//
// state   | meaning
// IDLE    | no frame yet, core free, host not accepted
// LEN     | waiting for the length byte
// DATA    | waiting for the next payload byte
// WRITE   | driving one byte onto the RAM bus for WR_CYCLES cycles
// CSUM    | waiting for the checksum byte
// DONE    | frame good, core released
// ERR     | checksum bad, core kept held
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter logic [ADDR_W-1:0] BASE_ADDR = DEFAULT_BASE_ADDR,
  parameter int unsigned       WR_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_req,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_data,
  output logic              mem_oe,
  output logic              mem_ena,
  output logic              mem_write,
  output logic              core_hold,
  output logic              done,
  output logic              err
);

  localparam logic [1:0] WR_LAST = 2'(WR_CYCLES - 1);

  state_t      state, next_state;
  logic [8:0]  count;
  logic [7:0]  sum;
  logic [1:0]  wcnt;
  logic        accept;
  logic        wr_last;
  logic        ready_d, strobe_d, hold_d, done_d, err_d;

  assign accept  = in_valid & in_ready;
  assign wr_last = (wcnt == 2'd0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE, S_DONE, S_ERR: if (load_req) next_state = S_LEN;
      S_LEN:   if (accept) next_state = S_DATA;
      S_DATA:  if (accept) next_state = S_WRITE;
      S_WRITE: if (wr_last) next_state = (count == 9'd1) ? S_CSUM : S_DATA;
      S_CSUM:  if (accept) next_state = (in_data == sum) ? S_DONE : S_ERR;
      default: next_state = S_IDLE;
    endcase
  end

  // Outputs are decoded from next_state and registered, so they line up with the state they describe.
  always_comb begin
    ready_d  = 1'b0;
    strobe_d = 1'b0;
    hold_d   = 1'b0;
    done_d   = 1'b0;
    err_d    = 1'b0;
    case (next_state)
      S_LEN, S_DATA, S_CSUM: begin
        ready_d = 1'b1;
        hold_d  = 1'b1;
      end
      S_WRITE: begin
        strobe_d = 1'b1;
        hold_d   = 1'b1;
      end
      S_DONE: done_d = 1'b1;
      S_ERR: begin
        err_d  = 1'b1;
        hold_d = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      in_ready  <= 1'b0;
      mem_oe    <= 1'b0;
      mem_ena   <= 1'b0;
      mem_write <= 1'b0;
      core_hold <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      in_ready  <= ready_d;
      mem_oe    <= strobe_d;
      mem_ena   <= strobe_d;
      mem_write <= strobe_d;
      core_hold <= hold_d;
      done      <= done_d;
      err       <= err_d;
    end
  end

  // Write-cycle timer is a down-counter loaded on byte accept; address/count step at its terminal count.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count    <= '0;
      sum      <= '0;
      wcnt     <= '0;
      mem_addr <= BASE_ADDR;
      mem_data <= '0;
    end else begin
      case (state)
        S_LEN: if (accept) begin
          count    <= payload_len(in_data);
          mem_addr <= BASE_ADDR;
          sum      <= '0;
        end
        S_DATA: if (accept) begin
          mem_data <= in_data;
          sum      <= sum + in_data;
          wcnt     <= WR_LAST;
        end
        S_WRITE: begin
          if (wr_last) begin
            mem_addr <= mem_addr + 8'd1;
            count    <= count - 9'd1;
          end else begin
            wcnt <= wcnt - 2'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// Self-checking bench: two loaders (default and FE-base/3-cycle writes) against a frame-level model.
module tb_prog_loader;
  import prog_loader_pkg::*;

  localparam logic [7:0] BASE_B = 8'hFE;
  localparam int         WR_B   = 3;

  logic       clk = 1'b0;
  logic       rst;
  logic       load_req  [2];
  logic       in_valid  [2];
  logic [7:0] in_data   [2];
  logic       in_ready  [2];
  logic [7:0] mem_addr  [2];
  logic [7:0] mem_data  [2];
  logic       mem_oe    [2];
  logic       mem_ena   [2];
  logic       mem_write [2];
  logic       core_hold [2];
  logic       done      [2];
  logic       err       [2];

  always #5 clk = ~clk;

  prog_loader dut_a (
    .clk(clk), .rst(rst), .load_req(load_req[0]), .in_data(in_data[0]), .in_valid(in_valid[0]),
    .in_ready(in_ready[0]), .mem_addr(mem_addr[0]), .mem_data(mem_data[0]), .mem_oe(mem_oe[0]),
    .mem_ena(mem_ena[0]), .mem_write(mem_write[0]), .core_hold(core_hold[0]), .done(done[0]),
    .err(err[0])
  );

  prog_loader #(.BASE_ADDR(BASE_B), .WR_CYCLES(WR_B)) dut_b (
    .clk(clk), .rst(rst), .load_req(load_req[1]), .in_data(in_data[1]), .in_valid(in_valid[1]),
    .in_ready(in_ready[1]), .mem_addr(mem_addr[1]), .mem_data(mem_data[1]), .mem_oe(mem_oe[1]),
    .mem_ena(mem_ena[1]), .mem_write(mem_write[1]), .core_hold(core_hold[1]), .done(done[1]),
    .err(err[1])
  );

  int checks = 0;
  int errors = 0;

  logic [7:0] ram      [2][256];
  int         nwr      [2];
  int         run_len  [2][512];
  logic [7:0] wr_addr  [2][512];
  int         wr_cyc   [2][512];
  int         unstable [2];
  int         stray    [2];
  bit         in_run   [2];
  logic [7:0] run_a    [2];
  logic [7:0] run_d    [2];
  int         cyc = 0;
  logic [7:0] pay      [256];

  function automatic logic [7:0] base_of(int u);
    return (u == 1) ? BASE_B : 8'h00;
  endfunction

  function automatic int wr_of(int u);
    return (u == 1) ? WR_B : 1;
  endfunction

  // Bus monitor: models the shared RAM and records every write window.
  always @(negedge clk) begin
    cyc++;
    for (int u = 0; u < 2; u++) begin
      if ((mem_oe[u] || mem_ena[u]) && !mem_write[u]) stray[u]++;
      if (mem_write[u] && in_ready[u]) stray[u]++;
      if (mem_write[u]) begin
        if (mem_ena[u] && mem_oe[u]) ram[u][mem_addr[u]] = mem_data[u];
        if (!in_run[u]) begin
          in_run[u] = 1'b1;
          run_a[u]  = mem_addr[u];
          run_d[u]  = mem_data[u];
          if (nwr[u] < 512) begin
            wr_addr[u][nwr[u]] = mem_addr[u];
            wr_cyc[u][nwr[u]]  = cyc;
            run_len[u][nwr[u]] = 1;
          end
          nwr[u]++;
        end else begin
          if (mem_addr[u] !== run_a[u] || mem_data[u] !== run_d[u]) unstable[u]++;
          if (nwr[u] <= 512) run_len[u][nwr[u]-1]++;
        end
      end else begin
        in_run[u] = 1'b0;
      end
    end
  end

  task automatic clear_log(int u);
    nwr[u] = 0;
    unstable[u] = 0;
    stray[u] = 0;
  endtask

  task automatic pulse_load(int u);
    load_req[u] = 1'b1;
    @(negedge clk);
    load_req[u] = 1'b0;
    checks++;
    if (core_hold[u] !== 1'b1 || in_ready[u] !== 1'b1 || done[u] !== 1'b0 || err[u] !== 1'b0) begin
      errors++;
      $display("FAIL load_start u%0d got hold=%b rdy=%b done=%b err=%b want 1 1 0 0",
               u, core_hold[u], in_ready[u], done[u], err[u]);
    end
  endtask

  task automatic send_byte(int u, logic [7:0] b, int gap);
    int t;
    repeat (gap) @(negedge clk);
    in_valid[u] = 1'b1;
    in_data[u]  = b;
    t = 0;
    while (in_ready[u] !== 1'b1 && t < 2000) begin
      @(negedge clk);
      t++;
    end
    checks++;
    if (in_ready[u] !== 1'b1) begin
      errors++;
      $display("FAIL handshake u%0d got in_ready=%b want 1 within 2000 cycles", u, in_ready[u]);
    end
    @(negedge clk);
    in_valid[u] = 1'b0;
  endtask

  // Sends a frame of n bytes from pay[] and checks the bus activity and final status against the model.
  task automatic run_frame(int u, int n, bit good, int gapmax, bit poke_load, bit check_rate);
    logic [7:0] s, cs;
    int bad_addr, bad_ram, bad_len, bad_rate;
    s = 8'h00;
    for (int i = 0; i < n; i++) s = 8'((int'(s) + int'(pay[i])) % 256);
    cs = good ? s : 8'(s + 8'($urandom_range(1, 255)));
    clear_log(u);
    pulse_load(u);
    send_byte(u, 8'(n % 256), $urandom_range(0, gapmax));
    for (int i = 0; i < n; i++) begin
      if (poke_load && i == 1) load_req[u] = 1'b1;
      send_byte(u, pay[i], $urandom_range(0, gapmax));
      load_req[u] = 1'b0;
    end
    send_byte(u, cs, $urandom_range(0, gapmax));

    checks++;
    if (done[u] !== good || err[u] !== !good || core_hold[u] !== !good) begin
      errors++;
      $display("FAIL status u%0d n=%0d got done=%b err=%b hold=%b want %b %b %b",
               u, n, done[u], err[u], core_hold[u], good, !good, !good);
    end
    checks++;
    if (nwr[u] !== n) begin
      errors++;
      $display("FAIL write_count u%0d got %0d want %0d", u, nwr[u], n);
    end
    checks++;
    if (unstable[u] !== 0 || stray[u] !== 0) begin
      errors++;
      $display("FAIL bus_window u%0d got unstable=%0d stray=%0d want 0 0", u, unstable[u], stray[u]);
    end
    bad_addr = 0; bad_ram = 0; bad_len = 0; bad_rate = 0;
    for (int i = 0; i < n && i < nwr[u]; i++) begin
      if (wr_addr[u][i] !== 8'((int'(base_of(u)) + i) % 256)) bad_addr++;
      if (run_len[u][i] !== wr_of(u)) bad_len++;
      if (ram[u][8'((int'(base_of(u)) + i) % 256)] !== pay[i]) bad_ram++;
      if (check_rate && i > 0 && (wr_cyc[u][i] - wr_cyc[u][i-1]) !== 1 + wr_of(u)) bad_rate++;
    end
    checks++;
    if (bad_addr != 0) begin
      errors++;
      $display("FAIL write_addr u%0d got %0d wrong addresses (first %h) want base %h upward",
               u, bad_addr, wr_addr[u][0], base_of(u));
    end
    checks++;
    if (bad_len != 0) begin
      errors++;
      $display("FAIL write_len u%0d got %0d windows (first %0d cycles) want %0d cycles each",
               u, bad_len, run_len[u][0], wr_of(u));
    end
    checks++;
    if (bad_ram != 0) begin
      errors++;
      $display("FAIL ram_data u%0d got %0d wrong bytes want 0", u, bad_ram);
    end
    if (check_rate) begin
      checks++;
      if (bad_rate != 0) begin
        errors++;
        $display("FAIL throughput u%0d got %0d bad byte spacings want %0d cycles/byte",
                 u, bad_rate, 1 + wr_of(u));
      end
    end
  endtask

  task automatic check_idle_outputs(int u, string tag);
    checks++;
    if (in_ready[u] !== 1'b0 || mem_oe[u] !== 1'b0 || mem_ena[u] !== 1'b0 || mem_write[u] !== 1'b0 ||
        core_hold[u] !== 1'b0 || done[u] !== 1'b0 || err[u] !== 1'b0 ||
        mem_addr[u] !== base_of(u) || mem_data[u] !== 8'h00) begin
      errors++;
      $display("FAIL %s u%0d got rdy=%b oe=%b ena=%b wr=%b hold=%b done=%b err=%b addr=%h data=%h want 0s addr=%h data=00",
               tag, u, in_ready[u], mem_oe[u], mem_ena[u], mem_write[u], core_hold[u], done[u], err[u],
               mem_addr[u], mem_data[u], base_of(u));
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    for (int u = 0; u < 2; u++) begin
      load_req[u] = 1'b0;
      in_valid[u] = 1'b0;
      in_data[u]  = 8'h00;
      in_run[u]   = 1'b0;
      clear_log(u);
    end
    repeat (3) @(negedge clk);
    for (int u = 0; u < 2; u++) check_idle_outputs(u, "reset");
    rst = 1'b1;
    repeat (2) @(negedge clk);
    for (int u = 0; u < 2; u++) check_idle_outputs(u, "idle_after_reset");
  endtask

  task automatic test_basic();
    pay[0] = 8'h01; pay[1] = 8'h02; pay[2] = 8'h03;
    run_frame(0, 3, 1'b1, 2, 1'b0, 1'b0);
  endtask

  task automatic test_bad_csum();
    pay[0] = 8'h01; pay[1] = 8'h02; pay[2] = 8'h03;
    run_frame(0, 3, 1'b0, 1, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    checks++;
    if (err[0] !== 1'b1 || core_hold[0] !== 1'b1) begin
      errors++;
      $display("FAIL err_sticky got err=%b hold=%b want 1 1", err[0], core_hold[0]);
    end
    for (int i = 0; i < 3; i++) pay[i] = 8'($urandom);
    run_frame(0, 3, 1'b1, 1, 1'b1, 1'b0);
  endtask

  task automatic test_wrap();
    pay[0] = 8'hAA; pay[1] = 8'hBB; pay[2] = 8'hCC; pay[3] = 8'hDD;
    run_frame(1, 4, 1'b1, 1, 1'b0, 1'b0);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 6; i++) pay[i] = 8'($urandom);
    run_frame(1, 6, 1'b1, 0, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) pay[i] = 8'($urandom);
    run_frame(0, 5, 1'b1, 0, 1'b0, 1'b1);
  endtask

  task automatic test_len256();
    for (int i = 0; i < 256; i++) pay[i] = 8'(i);
    run_frame(0, 256, 1'b1, 0, 1'b0, 1'b1);
  endtask

  task automatic test_random();
    for (int k = 0; k < 8; k++) begin
      int u, n;
      u = $urandom_range(0, 1);
      n = $urandom_range(1, 20);
      for (int i = 0; i < n; i++) pay[i] = 8'($urandom);
      run_frame(u, n, 1'($urandom_range(0, 1)), 2, 1'($urandom_range(0, 1)), 1'b0);
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 5; i++) pay[i] = 8'($urandom);
    clear_log(0);
    pulse_load(0);
    send_byte(0, 8'd5, 0);
    send_byte(0, pay[0], 0);
    send_byte(0, pay[1], 0);
    checks++;
    if (mem_write[0] !== 1'b1 || mem_addr[0] !== 8'h01) begin
      errors++;
      $display("FAIL second_write got wr=%b addr=%h want 1 01", mem_write[0], mem_addr[0]);
    end
    #2 rst = 1'b0;
    #1 check_idle_outputs(0, "async_reset");
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 4; i++) pay[i] = 8'($urandom);
    run_frame(0, 4, 1'b1, 1, 1'b0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_bad_csum();
    test_wrap();
    test_back_to_back();
    test_len256();
    test_random();
    test_reset_mid();
    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog got no completion want summary before time limit");
    $fatal(1, "watchdog");
  end

endmodule
